// File: rtl/ldpc_mem_pkg.sv
// Shared types and constants for the LDPC extrinsic-message memory controller.
package ldpc_mem_pkg;

    typedef enum logic {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } ext_ctrl_state_t;

    localparam int unsigned PORT_CNU = 0;
    localparam int unsigned PORT_VNU = 1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter; grant is combinational, pointer is registered.
module rr_arbiter_2
    import ldpc_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // High when the VNU port was granted most recently, so CNU wins the next conflict.
    logic last_vnu_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_vnu_q <= 1'b1;
        end else if (advance) begin
            last_vnu_q <= gnt[PORT_VNU];
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last_vnu_q ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/ext_ram_ctrl.sv
// Two-port arbitrated front end for an external single-port synchronous RAM,
// with a full-array zeroing sweep.
module ext_ram_ctrl
    import ldpc_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_chip_sel,
    output logic                  ram_write_en,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    // One spare bit so the terminal count never aliases with address 0 on wrap.
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    ext_ctrl_state_t  state_q, state_d;
    logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [1:0]       rd_pend_q, rd_pend_d;
    logic             clr_done_q, clr_done_d;
    logic [1:0]       req, gnt;
    logic             grant_any;

    assign req       = (state_q == SERVE) ? {req1_valid, req0_valid} : 2'b00;
    assign grant_any = |gnt;

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (grant_any),
        .gnt     (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SERVE;
            clr_cnt_q  <= '0;
            rd_pend_q  <= 2'b00;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_pend_q  <= rd_pend_d;
            clr_done_q <= clr_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        clr_done_d   = 1'b0;
        rd_pend_d    = gnt & ~{req1_we, req0_we};
        req0_ready   = gnt[PORT_CNU];
        req1_ready   = gnt[PORT_VNU];
        ram_chip_sel = 1'b0;
        ram_write_en = 1'b0;
        ram_address  = '0;
        ram_data_in  = '0;
        case (state_q)
            SERVE: begin
                if (gnt[PORT_CNU]) begin
                    ram_chip_sel = 1'b1;
                    ram_write_en = req0_we;
                    ram_address  = req0_addr;
                    ram_data_in  = req0_wdata;
                end else if (gnt[PORT_VNU]) begin
                    ram_chip_sel = 1'b1;
                    ram_write_en = req1_we;
                    ram_address  = req1_addr;
                    ram_data_in  = req1_wdata;
                end
                if (clr_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                ram_chip_sel = 1'b1;
                ram_write_en = 1'b1;
                ram_address  = clr_cnt_q[ADDR_WIDTH-1:0];
                if (clr_cnt_q == CNT_W'(RAM_DEPTH - 1)) begin
                    state_d    = SERVE;
                    clr_cnt_d  = '0;
                    clr_done_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = SERVE;
        endcase
    end

    assign clr_busy   = (state_q == CLEAR);
    assign clr_done   = clr_done_q;
    assign rsp0_valid = rd_pend_q[PORT_CNU];
    assign rsp1_valid = rd_pend_q[PORT_VNU];
    assign rsp0_rdata = rd_pend_q[PORT_CNU] ? ram_data_out : '0;
    assign rsp1_rdata = rd_pend_q[PORT_VNU] ? ram_data_out : '0;

endmodule

// File: tb/tb_ext_ram_ctrl.sv
// Scoreboard bench for ext_ram_ctrl with a behavioural synchronous RAM attached.
module tb_ext_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_we, req1_valid, req1_we;
    logic [7:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_rdata, rsp1_rdata;
    logic       clr_start, clr_busy, clr_done;
    logic [7:0] ram_address, ram_data_in, ram_data_out;
    logic       ram_chip_sel, ram_write_en;

    logic [7:0] mem    [256];
    logic [7:0] shadow [256];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ext_ram_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_we      (req0_we),
        .req0_addr    (req0_addr),
        .req0_wdata   (req0_wdata),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_we      (req1_we),
        .req1_addr    (req1_addr),
        .req1_wdata   (req1_wdata),
        .req1_ready   (req1_ready),
        .rsp0_valid   (rsp0_valid),
        .rsp0_rdata   (rsp0_rdata),
        .rsp1_valid   (rsp1_valid),
        .rsp1_rdata   (rsp1_rdata),
        .clr_start    (clr_start),
        .clr_busy     (clr_busy),
        .clr_done     (clr_done),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_chip_sel (ram_chip_sel),
        .ram_write_en (ram_write_en),
        .ram_data_out (ram_data_out)
    );

    // External RAM: synchronous write, one-cycle registered read.
    always @(posedge clk) begin
        if (ram_chip_sel) begin
            if (ram_write_en) mem[ram_address] <= ram_data_in;
            else              ram_data_out     <= mem[ram_address];
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pop the expected read data whenever a response is presented.
    always @(negedge clk) begin
        if (rsp0_valid) begin
            if (q0.size() == 0) check("rsp0_spurious", 32'(rsp0_valid), 32'd0);
            else                check("rsp0_data", 32'(rsp0_rdata), 32'(q0.pop_front()));
        end else begin
            check("rsp0_idle_zero", 32'(rsp0_rdata), 32'd0);
        end
        if (rsp1_valid) begin
            if (q1.size() == 0) check("rsp1_spurious", 32'(rsp1_valid), 32'd0);
            else                check("rsp1_data", 32'(rsp1_rdata), 32'(q1.pop_front()));
        end else begin
            check("rsp1_idle_zero", 32'(rsp1_rdata), 32'd0);
        end
    end

    // Drive one cycle of requests, check the expected grant and RAM strobe, push scoreboard.
    task automatic step(input logic v0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                        input logic v1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                        input logic [1:0] eg, input string nm);
        logic [17:0] exp_ram;
        req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
        @(negedge clk);
        check({nm, "_gnt"}, 32'({req1_ready, req0_ready}), 32'(eg));
        if (eg[0])      exp_ram = {1'b1, w0, a0, d0};
        else if (eg[1]) exp_ram = {1'b1, w1, a1, d1};
        else            exp_ram = 18'd0;
        check({nm, "_ram"}, 32'({ram_chip_sel, ram_write_en, ram_address, ram_data_in}), 32'(exp_ram));
        if (eg[0]) begin
            if (w0) shadow[a0] = d0;
            else    q0.push_back(shadow[a0]);
        end
        if (eg[1]) begin
            if (w1) shadow[a1] = d1;
            else    q1.push_back(shadow[a1]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        int  busy, dones;
        bit  fin, hit;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'(i * 3 + 1);
            shadow[i] = 8'(i * 3 + 1);
        end
        rst = 1'b1; clr_start = 1'b0;
        req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_outs", 32'({rsp1_valid, rsp0_valid, clr_busy, clr_done, ram_chip_sel}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Simultaneous reads alternate starting with port 0.
        step(1, 0, 8'h21, 8'h00, 1, 0, 8'h31, 8'h00, 2'b01, "rr0");
        step(1, 0, 8'h21, 8'h00, 1, 0, 8'h31, 8'h00, 2'b10, "rr1");
        step(1, 0, 8'h21, 8'h00, 1, 0, 8'h31, 8'h00, 2'b01, "rr2");
        step(1, 0, 8'h21, 8'h00, 1, 0, 8'h31, 8'h00, 2'b10, "rr3");

        // Write then read back on port 0.
        step(1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, 2'b01, "wr10");
        step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 2'b01, "rd10");
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00, "idle");

        for (int i = 0; i < 256; i++)
            step(0, 0, 8'h00, 8'h00, 1, 1, 8'(i), 8'hFF, 2'b10, "fill");

        // clr_start alongside a port 1 read whose response lands in the first CLEAR cycle.
        clr_start = 1'b1;
        step(0, 0, 8'h00, 8'h00, 1, 0, 8'h05, 8'h00, 2'b10, "clr_go");
        clr_start = 1'b0;
        for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
        req0_valid = 1; req0_we = 0; req0_addr = 8'h07; req0_wdata = 8'h00;
        req1_valid = 0;
        busy = 0; dones = 0; fin = 0;
        for (int c = 0; c < 400 && !fin; c++) begin
            clr_start = (c == 100);
            @(negedge clk);
            if (clr_done) dones++;
            if (clr_busy) begin
                check("clr_cycle",
                      32'({req1_ready, req0_ready, ram_chip_sel, ram_write_en, ram_address, ram_data_in}),
                      32'({2'b00, 2'b11, 8'(busy), 8'h00}));
                if (busy == 0) check("rsp1_in_clear", 32'(rsp1_valid), 32'd1);
                busy++;
            end else if (busy > 0) begin
                fin = 1;
                check("clr_done_first_serve", 32'(clr_done), 32'd1);
                check("pending_after_clear", 32'({req1_ready, req0_ready}), 32'd1);
                q0.push_back(shadow[8'h07]);
            end
            @(posedge clk); #1;
        end
        clr_start = 1'b0;
        req0_valid = 0;
        check("clr_busy_cycles", 32'(busy), 32'd256);
        check("clr_done_count", 32'(dones), 32'd1);

        for (int i = 0; i < 256; i++)
            step(1, 0, 8'(i), 8'h00, 0, 0, 8'h00, 8'h00, 2'b01, "rb");

        // Reset in the middle of a sweep.
        clr_start = 1'b1;
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00, "clr2");
        clr_start = 1'b0;
        hit = 0;
        for (int c = 0; c < 300 && !hit; c++) begin
            @(negedge clk);
            if (clr_busy && ram_address == 8'h40) hit = 1;
            else begin @(posedge clk); #1; end
        end
        check("rst_at_40_reached", 32'(hit), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_rst", 32'({clr_busy, clr_done, ram_chip_sel}), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("no_done_after_abort", 32'({clr_busy, clr_done}), 32'd0);
        end
        @(posedge clk); #1;
        // Pointer reset: port 0 wins the first conflict again.
        step(1, 0, 8'h40, 8'h00, 1, 0, 8'h41, 8'h00, 2'b01, "rr_post_rst");
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00, "tail");
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00, "tail");

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ext_ram_ctrl.md
EXT_RAM_CTRL -- requirements
Module: ext_ram_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_WIDTH, 8, extrinsic message width.
- ADDR_WIDTH, 8, RAM address width.
- RAM_DEPTH, 1 << ADDR_WIDTH, number of RAM entries.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid/req1_valid  in  1  access request (port 0 = CNU, port 1 = VNU).
- req0_we/req1_we  in  1  1 = write, 0 = read.
- req0_addr/req1_addr  in  ADDR_WIDTH  target address.
- req0_wdata/req1_wdata  in  DATA_WIDTH  write data.
- req0_ready/req1_ready  out  1  grant; transfer when valid & ready.
- rsp0_valid/rsp1_valid  out  1  read data valid.
- rsp0_rdata/rsp1_rdata  out  DATA_WIDTH  read data.
- clr_start  in  1  pulse; zero the whole RAM.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when the clear finishes.
- ram_address  out  ADDR_WIDTH  to RAM address.
- ram_data_in  out  DATA_WIDTH  to RAM data_in.
- ram_chip_sel  out  1  to RAM chip_sel.
- ram_write_en  out  1  to RAM write_en.
- ram_data_out  in  DATA_WIDTH  from RAM data_out (synchronous read, 1-cycle).

Function
REQ-003 The FSM SHALL have states SERVE and CLEAR; reset state is SERVE.
REQ-004 In SERVE, readyN SHALL be combinational: at most one ready is high, and a ready is high only when its valid is high.
REQ-005 A single valid request in SERVE SHALL be granted in the same cycle.
REQ-006 When both are valid, the grant SHALL go to the port not granted most recently (round-robin); the last-grant pointer updates on every grant.
REQ-007 On a grant, the ram_* signals SHALL combinationally carry the winner's addr, wdata and we, with ram_chip_sel=1.
REQ-008 With no grant and not in CLEAR, ram_chip_sel, ram_write_en, ram_address and ram_data_in SHALL all be 0.
REQ-009 A read granted in cycle T SHALL assert rspN_valid in cycle T+1 only, with rspN_rdata = ram_data_out. Writes produce no response.
REQ-010 rspN_rdata SHALL be 0 when rspN_valid = 0.
REQ-011 clr_start sampled in SERVE:
- That cycle's arbitration proceeds normally.
- The state becomes CLEAR next cycle.
REQ-012 In CLEAR:
- Both readys SHALL be 0 and clr_busy = 1.
- The block SHALL write 0 to addresses 0..RAM_DEPTH-1 in ascending order, one per cycle (chip_sel=1, write_en=1).
REQ-013 After the write to address RAM_DEPTH-1:
- The state SHALL return to SERVE.
- clr_done SHALL pulse in the first SERVE cycle.
- Total clear occupancy is exactly RAM_DEPTH cycles.
REQ-014 clr_start while in CLEAR SHALL be ignored.
REQ-015 A read response due in the first CLEAR cycle (granted in the clr_start cycle) SHALL still be delivered.
REQ-016 The clear address counter SHALL be ADDR_WIDTH+1 bits wide so termination at RAM_DEPTH-1 does not alias on wrap.
REQ-017 Requests held valid during CLEAR SHALL remain pending and arbitrate normally on return to SERVE.

Reset
REQ-018 On rst = 1, at the next edge:
- State = SERVE, clear counter = 0.
- The last-grant pointer SHALL favour port 0 on the first conflict.
- rsp0_valid, rsp1_valid, clr_busy and clr_done SHALL be 0.
REQ-019 Reset during CLEAR SHALL abort the sweep; RAM contents are then unspecified and clr_done SHALL NOT pulse.
REQ-020 Reset SHALL cancel any pending read response.

Structure
REQ-021 Package ldpc_mem_pkg SHALL hold the ext_ctrl_state_t enum (SERVE, CLEAR) and the port-index constants PORT_CNU=0 and PORT_VNU=1.
REQ-022 Arbitration SHALL be a sub-module rr_arbiter_2:
- Inputs: req[1:0], advance.
- Output: one-hot gnt[1:0].
- Holds the last-grant pointer.
REQ-023 The RAM SHALL be instantiated outside this block.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Port 0 writes 0x5A to addr 0x10, then reads 0x10 -> rsp0_valid one cycle after the grant, rsp0_rdata = 0x5A.
- Both ports read simultaneously for 4 cycles after reset -> grants in order 0,1,0,1; each rsp matches its own port.
- clr_start after filling addresses 0..255 with 0xFF -> 256 cycles of clr_busy with readys low, clr_done pulses once, all reads return 0x00.
- Port 1 read granted in the clr_start cycle -> rsp1_valid in the first CLEAR cycle with correct data.
- rst asserted at clear address 0x40 -> next cycle in SERVE, clr_busy = 0, no clr_done, ram_chip_sel = 0.
- Second clr_start mid-clear -> clear still ends after exactly 256 cycles with a single clr_done.
